// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read packer.
// Holds the packer state encoding and the default lane geometry.
package fifo_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PACK       = 4;

endpackage : fifo_pkg

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads PACK entries from a FIFO with one-cycle read latency
// and presents them as one wide word, lane 0 in the LSBs.
// Optional feature macro: FIFO_RD_PACKER_FLUSH_EN compiles in support for
// emitting a partial word on request; without it the flush port is ignored.
// PACK is meant to lie in 2..8.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       empty,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_en,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CNT_W = $clog2(PACK + 1);
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACK - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t                             state;
    logic [CNT_W-1:0]                   issued;
    logic [CNT_W-1:0]                   captured;
    logic [CNT_W-1:0]                   captured_next;
    logic [PACK-1:0][DATA_WIDTH-1:0]    lanes;
    logic                               rd_pending;
    logic                               flush_pending;
    logic                               flush_start;
    logic                               flush_block;
    logic [PACK-1:0]                    keep_next;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // A flush arriving in FILL stops reads immediately, in its own cycle too.
    assign flush_start = flush && (state == FILL);
    assign flush_block = flush_pending || flush_start;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_start  = 1'b0;
    assign flush_block  = 1'b0;
`endif

    // Reads are only requested while filling, with data available and room left.
    assign rd_en = rst && (state == FILL) && !empty && (issued < PACK_CNT) && !flush_block;

    // Count of lanes that will be valid once this cycle's capture lands.
    assign captured_next = captured + (rd_pending ? ONE_CNT : '0);

    // Lane mask for the word about to be presented.
    always_comb begin
        keep_next = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        for (int i = 0; i < PACK; i++) begin
            keep_next[i] = (CNT_W'(i) < captured_next);
        end
`else
        keep_next = '1;
`endif
    end

    assign out_data = lanes;

    // Packer state machine: issue reads, capture returning data, present the word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= FILL;
            issued        <= '0;
            captured      <= '0;
            lanes         <= '0;
            rd_pending    <= 1'b0;
            flush_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_keep      <= '0;
        end else begin
            rd_pending <= rd_en;

            if (rd_en) begin
                issued <= issued + ONE_CNT;
            end

            if (rd_pending) begin
                for (int i = 0; i < PACK; i++) begin
                    if (captured == CNT_W'(i)) begin
                        lanes[i] <= rd_data;
                    end
                end
                captured <= captured_next;
            end

            case (state)
                FILL: begin
                    if (rd_en && (issued == LAST_CNT)) begin
                        state <= DRAIN;
                    end else if (flush_pending && !rd_pending) begin
                        if (captured != '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_keep  <= keep_next;
                        end else begin
                            flush_pending <= 1'b0;
                        end
                    end
                    if (flush_start) begin
                        flush_pending <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (rd_pending && (captured_next == PACK_CNT)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_keep  <= keep_next;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        state         <= FILL;
                        issued        <= '0;
                        captured      <= '0;
                        lanes         <= '0;
                        flush_pending <= 1'b0;
                        out_valid     <= 1'b0;
                        out_keep      <= '0;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule : fifo_rd_packer

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed checks of the FIFO read packer with PACK=4,
// DATA_WIDTH=8, against a small FIFO model with one-cycle read latency.
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        empty;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_en;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;
    int         viol = 0;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign empty = force_empty || (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    // FIFO model: data appears on rd_data the cycle after an accepted read.
    always @(posedge clk) begin
        if (rd_en && !empty) begin
            rd_data <= mem[rd_ptr[5:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Flags any cycle in which a read is requested from an empty FIFO.
    always @(negedge clk) begin
        if (rd_en && empty) viol <= viol + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (3) @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_keep !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_keep: got %b expected 0000", out_keep); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
    endtask

    task automatic test_basic;
        logic early;
        early = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("[TB] FAIL first_rd_en: got %0b expected 1", rd_en); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got %0b expected 0", early); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_cycle5: got %0b expected 1", out_valid); end
        checks++; if (out_data !== 32'h44332211) begin errors++; $display("[TB] FAIL basic_data: got %h expected 44332211", out_data); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("[TB] FAIL basic_keep: got %b expected 1111", out_keep); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_rd_en: got %0b expected 0", rd_en); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_hs_valid: got %0b expected 0", out_valid); end
        checks++; if (out_keep !== 4'b0000) begin errors++; $display("[TB] FAIL basic_after_hs_keep: got %b expected 0000", out_keep); end
    endtask

    task automatic test_backpressure;
        int n;
        int bad;
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_timeout: got %0b expected 1", out_valid); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_data !== 32'hA4A3A2A1 || out_valid !== 1'b1 || rd_en !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_hold_stable: got %0d bad cycles expected 0", bad); end
        checks++; if (rd_ptr !== 8) begin errors++; $display("[TB] FAIL bp_fifo_untouched: got rd_ptr %0d expected 8", rd_ptr); end
        out_ready = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_handshake_bubble: got %0b expected 0", rd_en); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_hs_valid: got %0b expected 0", out_valid); end
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'hB4B3B2B1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_word: got %h valid %0b expected B4B3B2B1 valid 1", out_data, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_hs: got %0b expected 0", out_valid); end
    endtask

    task automatic test_underflow;
        int n;
        int extra;
        out_ready = 1'b1;
        push(8'h11); push(8'h22);
        repeat (8) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL uf_no_early_word: got %0b expected 0", out_valid); end
        push(8'h33); push(8'h44);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'h44332211 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL uf_word: got %h valid %0b expected 44332211 valid 1", out_data, out_valid); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("[TB] FAIL uf_keep: got %b expected 1111", out_keep); end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL uf_no_dup: got %0d extra valid cycles expected 0", extra); end
    endtask

    task automatic test_reset_in_drain;
        int n;
        out_ready = 1'b1;
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_rst_valid: got %0b expected 0", out_valid); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL drain_rst_rd_en: got %0b expected 0", rd_en); end
        rst = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'h64636261 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_next_word: got %h valid %0b expected 64636261 valid 1", out_data, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_flush;
        int n;
        int extra;
        out_ready = 1'b1;
        push(8'hAA); push(8'hBB);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'h0000BBAA || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_data: got %h valid %0b expected 0000BBAA valid 1", out_data, out_valid); end
        checks++; if (out_keep !== 4'b0011) begin errors++; $display("[TB] FAIL flush_keep: got %b expected 0011", out_keep); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_hs: got %0b expected 0", out_valid); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL flush_zero_lanes: got %0d valid cycles expected 0", extra); end
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'hC4C3C2C1 || out_keep !== 4'b1111) begin errors++; $display("[TB] FAIL flush_resume: got %h keep %b expected C4C3C2C1 keep 1111", out_data, out_keep); end
        @(negedge clk);
`else
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL flush_ignored: got %0d valid cycles expected 0", extra); end
        push(8'hCC); push(8'hDD);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_data !== 32'hDDCCBBAA || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_ignored_word: got %h valid %0b expected DDCCBBAA valid 1", out_data, out_valid); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("[TB] FAIL flush_ignored_keep: got %b expected 1111", out_keep); end
        @(negedge clk);
`endif
    endtask

    task automatic test_empty_forced;
        int start_ptr;
        force_empty = 1'b1;
        start_ptr = rd_ptr;
        push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        repeat (10) @(negedge clk);
        checks++; if (rd_ptr !== start_ptr) begin errors++; $display("[TB] FAIL forced_empty_no_read: got rd_ptr %0d expected %0d", rd_ptr, start_ptr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL forced_empty_valid: got %0b expected 0", out_valid); end
        checks++; if (viol !== 0) begin errors++; $display("[TB] FAIL rd_en_while_empty: got %0d cycles expected 0", viol); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_underflow;
        test_reset_in_drain;
        test_flush;
        test_empty_forced;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d checks %0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_fifo_rd_packer
